// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Writer side of the program memory. It consumes a little-endian byte stream
// (2-byte word count N, then N 32-bit words with the least-significant byte
// first) and writes each assembled word into program memory through a
// single-cycle write port. The CPU is held until a complete image is loaded.
//
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN
//   When defined, an 8-bit XOR of all data bytes must follow the image. A
//   match finishes the load; a mismatch aborts it.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   start         in   single-cycle pulse that begins a load (IDLE/DONE/ERROR)
//   byte_in       in   stream data byte
//   byte_valid    in   byte_in is valid
//   byte_ready    out  loader accepts a byte this cycle
//   pm_we         out  program memory write enable, one pulse per word
//   pm_addr       out  program memory word address
//   pm_wdata      out  program memory write data
//   cpu_hold      out  CPU stalled while 1 (low only once an image is loaded)
//   load_done     out  image loaded successfully
//   load_err      out  load aborted (N too large or checksum mismatch)
//   words_loaded  out  words written in the current load
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int program_mem_width = 32,
  parameter int program_mem_depth = 4096,
  parameter int program_mem_addr  = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [7:0]                    byte_in,
  input  logic                          byte_valid,
  output logic                          byte_ready,
  output logic                          pm_we,
  output logic [program_mem_addr-1:0]   pm_addr,
  output logic [program_mem_width-1:0]  pm_wdata,
  output logic                          cpu_hold,
  output logic                          load_done,
  output logic                          load_err,
  output logic [program_mem_addr:0]     words_loaded
);

  localparam int          WL_W    = program_mem_addr + 1;
  localparam logic [15:0] DEPTH16 = 16'(program_mem_depth);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_LO = 3'd1,
    S_HDR_HI = 3'd2,
    S_LOAD   = 3'd3,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    S_CHECK  = 3'd4,
`endif
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic                          r_byte_ready;
  logic                          r_pm_we;
  logic [program_mem_addr-1:0]   r_pm_addr;
  logic [program_mem_width-1:0]  r_pm_wdata;
  logic                          r_cpu_hold;
  logic                          r_load_done;
  logic                          r_load_err;
  logic [WL_W-1:0]               r_words_loaded;
  logic [1:0]                    r_byte_idx;
  logic [7:0]                    r_n_lo;
  logic [15:0]                   r_n;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]                    r_xsum;
`endif

  logic                          w_accept;
  logic                          w_start_ok;
  logic [15:0]                   w_n_full;
  logic [WL_W-1:0]               w_wl_inc;
  logic                          w_last_word;
  logic                          w_ready_nxt;

  // Handshake, header assembly and end-of-image detection
  always_comb begin
    w_accept    = byte_valid & r_byte_ready;
    w_n_full    = {byte_in, r_n_lo};
    w_wl_inc    = r_words_loaded + WL_W'(1);
    w_last_word = (16'(w_wl_inc) == r_n);
    w_start_ok  = start & ((r_state == S_IDLE) || (r_state == S_DONE) ||
                           (r_state == S_ERROR));
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_nxt = S_HDR_LO;
        else            w_state_nxt = S_IDLE;
      end
      S_HDR_LO: begin
        if (w_accept) w_state_nxt = S_HDR_HI;
        else          w_state_nxt = S_HDR_LO;
      end
      S_HDR_HI: begin
        if (!w_accept)                w_state_nxt = S_HDR_HI;
        else if (w_n_full == 16'd0)   w_state_nxt = S_DONE;
        else if (w_n_full > DEPTH16)  w_state_nxt = S_ERROR;
        else                          w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (w_accept && (r_byte_idx == 2'd3) && w_last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          w_state_nxt = S_CHECK;
`else
          w_state_nxt = S_DONE;
`endif
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (!w_accept)              w_state_nxt = S_CHECK;
        else if (byte_in == r_xsum) w_state_nxt = S_DONE;
        else                        w_state_nxt = S_ERROR;
      end
`endif
      S_DONE: begin
        if (w_start_ok) w_state_nxt = S_HDR_LO;
        else            w_state_nxt = S_DONE;
      end
      S_ERROR: begin
        if (w_start_ok) w_state_nxt = S_HDR_LO;
        else            w_state_nxt = S_ERROR;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bytes are taken in every state that is still consuming the stream
  always_comb begin
    case (w_state_nxt)
      S_HDR_LO, S_HDR_HI, S_LOAD: w_ready_nxt = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK:                    w_ready_nxt = 1'b1;
`endif
      default:                    w_ready_nxt = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Status flags registered from the next state so they align with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_ready <= 1'b0;
      r_cpu_hold   <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_byte_ready <= w_ready_nxt;
      r_cpu_hold   <= (w_state_nxt != S_DONE);
      r_load_done  <= (w_state_nxt == S_DONE);
      r_load_err   <= (w_state_nxt == S_ERROR);
    end
  end

  // Header capture, word assembly and memory write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pm_we        <= 1'b0;
      r_pm_addr      <= '0;
      r_pm_wdata     <= '0;
      r_words_loaded <= '0;
      r_byte_idx     <= 2'd0;
      r_n_lo         <= 8'd0;
      r_n            <= 16'd0;
    end else begin
      r_pm_we <= 1'b0;
      if (w_start_ok) begin
        r_words_loaded <= '0;
        r_byte_idx     <= 2'd0;
      end
      if ((r_state == S_HDR_LO) && w_accept) r_n_lo <= byte_in;
      if ((r_state == S_HDR_HI) && w_accept) r_n    <= w_n_full;
      if ((r_state == S_LOAD) && w_accept) begin
        // Lane select: byte index 0..3 maps to bits [7:0]..[31:24]
        r_pm_wdata[{r_byte_idx, 3'b000} +: 8] <= byte_in;
        r_byte_idx <= r_byte_idx + 2'd1;
        if (r_byte_idx == 2'd3) begin
          // Word complete: write pulse next cycle at the pre-increment count
          r_pm_we        <= 1'b1;
          r_pm_addr      <= r_words_loaded[program_mem_addr-1:0];
          r_words_loaded <= w_wl_inc;
        end
      end
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  // Running XOR of data bytes only; header bytes are excluded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_xsum <= 8'd0;
    else if (w_start_ok)                   r_xsum <= 8'd0;
    else if ((r_state == S_LOAD) && w_accept) r_xsum <= r_xsum ^ byte_in;
    else                                   r_xsum <= r_xsum;
  end
`endif

  assign byte_ready   = r_byte_ready;
  assign pm_we        = r_pm_we;
  assign pm_addr      = r_pm_addr;
  assign pm_wdata     = r_pm_wdata;
  assign cpu_hold     = r_cpu_hold;
  assign load_done    = r_load_done;
  assign load_err     = r_load_err;
  assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Directed bench for program_loader. Expected memory writes are pushed to a
// scoreboard queue as words are sent and popped by a monitor on every pm_we.
// Build with +define+PROGRAM_LOADER_CHECKSUM_EN to cover the checksum option.
// -----------------------------------------------------------------------------
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        pm_we;
  logic [11:0] pm_addr;
  logic [31:0] pm_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [12:0] words_loaded;

  program_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .pm_we        (pm_we),
    .pm_addr      (pm_addr),
    .pm_wdata     (pm_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_we     = 0;
  logic [7:0] tb_xor   = 8'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every write pulse must match the oldest expected write
  always @(negedge clk) begin
    if (pm_we === 1'b1) begin
      wr_t e;
      n_we++;
      n_checks++;
      assert (sb_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_we: observed write addr 0x%0h data 0x%0h expected none",
               pm_addr, pm_wdata);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("wr_addr", 64'(pm_addr), 64'(e.addr));
        check("wr_data", 64'(pm_wdata), 64'(e.data));
      end
    end
  end

  task automatic pulse_start();
    byte_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tb_xor = 8'd0;
  endtask

  // Present one byte (entered and left on a negedge), then idle for gap cycles.
  // Right after acceptance, pm_we must equal we_exp (1 for a word's 4th byte).
  task automatic send_byte(input logic [7:0] b, input int gap, input bit is_data, input bit we_exp);
    int w = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      n_checks++;
      n_fail++;
      $error("FAIL ready_timeout: observed byte_ready=%b for 50 cycles expected 1", byte_ready);
    end
    if (is_data) tb_xor = tb_xor ^ b;
    @(negedge clk);
    byte_valid = 1'b0;
    if (is_data) check("we_timing", 64'(pm_we), 64'(we_exp));
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [15:0] n, input int gap);
    send_byte(n[7:0], gap, 1'b0, 1'b0);
    send_byte(n[15:8], gap, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [11:0] addr, input logic [31:0] word, input int gap);
    wr_t e;
    e.addr = addr;
    e.data = word;
    sb_q.push_back(e);
    for (int i = 0; i < 4; i++) send_byte(word[8*i +: 8], gap, 1'b1, (i == 3));
  endtask

  task automatic send_cksum(input int gap);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(tb_xor, gap, 1'b0, 1'b0);
`else
    repeat (gap) @(negedge clk);
`endif
  endtask

  task automatic check_done(input string tag, input logic [12:0] wl);
    @(negedge clk);
    check({tag, "_done"}, 64'(load_done), 64'd1);
    check({tag, "_err"}, 64'(load_err), 64'd0);
    check({tag, "_hold"}, 64'(cpu_hold), 64'd0);
    check({tag, "_ready"}, 64'(byte_ready), 64'd0);
    check({tag, "_words"}, 64'(words_loaded), 64'(wl));
    check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 64'(byte_ready), 64'd0);
    check({tag, "_we"}, 64'(pm_we), 64'd0);
    check({tag, "_addr"}, 64'(pm_addr), 64'd0);
    check({tag, "_wdata"}, 64'(pm_wdata), 64'd0);
    check({tag, "_hold"}, 64'(cpu_hold), 64'd1);
    check({tag, "_done"}, 64'(load_done), 64'd0);
    check({tag, "_err"}, 64'(load_err), 64'd0);
    check({tag, "_words"}, 64'(words_loaded), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int we_before;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(byte_ready), 64'd0);

    // Two-word image, continuous valid
    pulse_start();
    send_hdr(16'd2, 0);
    send_word(12'd0, 32'h0060_0173, 0);
    send_word(12'd1, 32'h00A0_0173, 0);
    send_cksum(0);
    check_done("t1", 13'd2);

    // Empty image: straight to DONE with no write
    we_before = n_we;
    pulse_start();
    check("restart_hold", 64'(cpu_hold), 64'd1);
    send_hdr(16'd0, 0);
    check_done("t2", 13'd0);
    check("t2_no_we", 64'(n_we - we_before), 64'd0);

    // N = 4097 is rejected, then recovery through start
    pulse_start();
    send_hdr(16'h1001, 0);
    @(negedge clk);
    check("t3_err", 64'(load_err), 64'd1);
    check("t3_hold", 64'(cpu_hold), 64'd1);
    check("t3_ready", 64'(byte_ready), 64'd0);
    check("t3_done", 64'(load_done), 64'd0);
    start = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("t3_restart_ready", 64'(byte_ready), 64'd1);
    check("t3_restart_err", 64'(load_err), 64'd0);
    tb_xor = 8'd0;
    send_hdr(16'd1, 0);
    send_word(12'd0, 32'hDEAD_BEEF, 0);
    send_cksum(0);
    check_done("t3", 13'd1);

    // Same image as the first load with 3-cycle gaps between bytes
    pulse_start();
    send_hdr(16'd2, 3);
    send_word(12'd0, 32'h0060_0173, 3);
    send_word(12'd1, 32'h00A0_0173, 3);
    send_cksum(3);
    check_done("t4", 13'd2);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Correct and wrong checksum bytes
    pulse_start();
    send_hdr(16'd1, 0);
    send_word(12'd0, 32'h4433_2211, 0);
    send_byte(8'h44, 0, 1'b0, 1'b0);
    check_done("ck_ok", 13'd1);
    pulse_start();
    send_hdr(16'd1, 0);
    send_word(12'd0, 32'h4433_2211, 0);
    send_byte(8'h45, 0, 1'b0, 1'b0);
    @(negedge clk);
    check("ck_bad_err", 64'(load_err), 64'd1);
    check("ck_bad_hold", 64'(cpu_hold), 64'd1);
    check("ck_bad_done", 64'(load_done), 64'd0);
`endif

    // Full-depth image: last address 4095, count ends at 4096
    pulse_start();
    send_hdr(16'd4096, 0);
    for (int i = 0; i < 4096; i++) begin
      logic [11:0] a;
      a = 12'(i);
      send_word(a, {a, 8'h5A, ~a}, 0);
    end
    send_cksum(0);
    check_done("full", 13'd4096);

    // Reset after 6 data bytes of an N=2 load
    we_before = n_we;
    pulse_start();
    send_hdr(16'd2, 0);
    send_word(12'd0, 32'h0060_0173, 0);
    send_byte(8'h73, 0, 1'b1, 1'b0);
    send_byte(8'h01, 0, 1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    check("midrst_one_we", 64'(n_we - we_before), 64'd1);
    check("midrst_sb_empty", 64'(sb_q.size()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_hold", 64'(cpu_hold), 64'd1);
    check("post_rst_ready", 64'(byte_ready), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
